// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the up/down modulo counter
// Purpose : direction encodings, default parameter values and the load
//           saturation helper used by tt_um_updown_counter_param.
// Ports   : none (package)
// Macro   : none referenced here (see COUNTER_PRESCALE_EN in the top)
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_MODULUS    = 256;
    localparam int DEF_PRESCALE_W = 4;

    // Wide enough for WIDTH up to 16 and MODULUS up to 2**16.
    localparam int SAT_W = 17;

    // Clamp a load value into the legal count range 0..modulus-1.
    function automatic logic [SAT_W-1:0] sat_load(input logic [SAT_W-1:0] val,
                                                  input logic [SAT_W-1:0] modulus);
        return (val >= modulus) ? (modulus - SAT_W'(1)) : val;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - step-rate prescaler for the up/down counter
// Purpose : produces tick once every div+1 enabled cycles.
// Ports   : clk, rst_n (async active-low), en (advance), restart (zero the
//           count, wins over en), div (divisor-1) -> tick (combinational).
module counter_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [PRESCALE_W-1:0] presc_next;

    assign tick = (presc_cnt == div);

    always_comb begin
        presc_next = presc_cnt;
        if (restart) begin
            presc_next = '0;
        end else if (en) begin
            presc_next = tick ? '0 : (presc_cnt + PRESCALE_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_next;
        end
    end

endmodule

// File: rtl/tt_um_updown_counter_param.sv
// rtl/tt_um_updown_counter_param.sv - parametrised up/down modulo-N counter
// Purpose : modulo-MODULUS up/down counter with enable, synchronous clear,
//           saturating parallel load, terminal-count pulse, sticky wrap flag
//           and compare-match output.
// Macro   : COUNTER_PRESCALE_EN adds the presc_div port and a prescaler that
//           limits steps to one every presc_div+1 enabled cycles.
// Ports   : clk, rst_n (async active-low), ena (power-good, freezes state),
//           en, up_dn (1=up), clear, load, load_val, cmp_val,
//           presc_div (macro only) -> count, tc, wrap_flag, match.
module tt_um_updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      cmp_val,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap_flag,
    output logic                  match
);

    // One extra bit so the +1/-1 arithmetic never silently rolls over at 2**WIDTH.
    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic             tick;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             wrap_next;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en && ena),
        .restart (ena && (clear || load)),
        .div     (presc_div),
        .tick    (tick)
    );
`else
    logic [PRESCALE_W-1:0] unused_presc_w;
    assign unused_presc_w = '0;
    assign tick           = 1'b1;
`endif

    assign count_ext = {1'b0, count};
    assign match     = (count == cmp_val);

    // tc defaults low so it is a single-cycle pulse and stays low on stalls.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        wrap_next  = wrap_flag;
        if (ena) begin
            if (clear) begin
                count_next = '0;
                wrap_next  = 1'b0;
            end else if (load) begin
                count_next = WIDTH'(sat_load(SAT_W'(load_val), SAT_W'(MODULUS)));
            end else if (en && tick) begin
                if (up_dn == DIR_UP) begin
                    if (count_ext == MAX) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = WIDTH'(count_ext + ONE);
                    end
                end else begin
                    if (count_ext == '0) begin
                        count_next = WIDTH'(MAX);
                        tc_next    = 1'b1;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = WIDTH'(count_ext - ONE);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            tc        <= 1'b0;
            wrap_flag <= 1'b0;
        end else begin
            count     <= count_next;
            tc        <= tc_next;
            wrap_flag <= wrap_next;
        end
    end

endmodule

// File: tb/tb_tt_um_updown_counter_param.sv
// tb/tb_tt_um_updown_counter_param.sv - directed self-checking bench for the up/down counter
module tb_tt_um_updown_counter_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       en;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cmp_val;
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] presc_div;
`endif
    logic [3:0] count;
    logic       tc;
    logic       wrap_flag;
    logic       match;

    int checks   = 0;
    int failures = 0;
    int exp_steps;

    always #5 clk = ~clk;

    tt_um_updown_counter_param #(
        .WIDTH      (4),
        .MODULUS    (10),
        .PRESCALE_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .en        (en),
        .up_dn     (up_dn),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .cmp_val   (cmp_val),
`ifdef COUNTER_PRESCALE_EN
        .presc_div (presc_div),
`endif
        .count     (count),
        .tc        (tc),
        .wrap_flag (wrap_flag),
        .match     (match)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input int t, input int w);
        chk({tag, "_count"}, 32'(count), c);
        chk({tag, "_tc"}, 32'(tc), t);
        chk({tag, "_wrap"}, 32'(wrap_flag), w);
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        en       = 1'b0;
        up_dn    = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        cmp_val  = 4'd15;
`ifdef COUNTER_PRESCALE_EN
        presc_div = 4'd2;
`endif
        #2;
        chk_state("reset", 0, 0, 0);
        chk("reset_match", 32'(match), 0);
        edge_wait();
        edge_wait();
        rst_n = 1'b1;

        // Up count, 12 edges: 1..9,0,1,2 with the tc pulse on the wrap edge.
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edge_wait();
            chk_state($sformatf("up%0d", k), k % 10, (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0);
        end

        // Stalled: count holds, tc stays low.
        en = 1'b0;
        edge_wait();
        chk_state("stall", 2, 0, 1);

        // Clear, then compare match exactly at 5.
        clear = 1'b1;
        edge_wait();
        clear = 1'b0;
        chk_state("clear", 0, 0, 0);
        cmp_val = 4'd5;
        chk("match_at0", 32'(match), 0);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            edge_wait();
            chk($sformatf("match_at%0d", k), 32'(match), (k == 5) ? 1 : 0);
        end
        en = 1'b0;
        edge_wait();
        chk_state("hold5", 5, 0, 0);
        chk("hold5_match", 32'(match), 1);
        cmp_val = 4'd15;

        // Down from zero wraps to 9 immediately.
        clear = 1'b1;
        edge_wait();
        clear = 1'b0;
        up_dn = 1'b0;
        en    = 1'b1;
        edge_wait();
        chk_state("dn1", 9, 1, 1);
        edge_wait();
        chk_state("dn2", 8, 0, 1);
        edge_wait();
        chk_state("dn3", 7, 0, 1);
        up_dn = 1'b1;
        edge_wait();
        chk_state("dirchg", 8, 0, 1);

        // Saturating load keeps wrap_flag.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd13;
        edge_wait();
        chk_state("load13", 9, 0, 1);
        load_val = 4'd3;
        edge_wait();
        chk_state("load3", 3, 0, 1);

        // Load and clear together: clear wins.
        clear    = 1'b1;
        load_val = 4'd6;
        edge_wait();
        clear = 1'b0;
        load  = 1'b0;
        chk_state("ldclr", 0, 0, 0);

        // ena low blocks step, load and clear.
        ena      = 1'b0;
        en       = 1'b1;
        load     = 1'b1;
        load_val = 4'd4;
        edge_wait();
        chk_state("ena0", 0, 0, 0);
        load = 1'b0;
        ena  = 1'b1;

        // Clear on the same edge as an up wrap: clear wins.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd9;
        edge_wait();
        load  = 1'b0;
        en    = 1'b1;
        clear = 1'b1;
        edge_wait();
        clear = 1'b0;
        chk_state("clrwrap", 0, 0, 0);

        // Async reset mid-count at count=7, wrap_flag=1.
        en   = 1'b0;
        load = 1'b1;
        edge_wait();
        load = 1'b0;
        en   = 1'b1;
        edge_wait();
        chk_state("prewrap", 0, 1, 1);
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd7;
        edge_wait();
        load = 1'b0;
        chk_state("pre_rst", 7, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0);
        edge_wait();
        rst_n = 1'b1;

        // Prescale: 9 enabled cycles give 3 steps with presc_div=2, else 9.
`ifdef COUNTER_PRESCALE_EN
        exp_steps = 3;
`else
        exp_steps = 9;
`endif
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            edge_wait();
        end
        en = 1'b0;
        chk("presc_steps", 32'(count), exp_steps);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
